// File: rtl/retire_ctrl_pkg.sv
// Shared retirement types: ROB exit packet, retire FSM state type and default widths.
`default_nettype none

package retire_ctrl_pkg;

   localparam int RC_N               = 3;
   localparam int RC_PHYS_REG_IDX_SZ = 6;
   localparam int RC_ARCH_REG_BITS   = 5;

   typedef logic [1:0] retire_state_t;

   localparam retire_state_t RS_RUN    = 2'd0;
   localparam retire_state_t RS_FLUSH  = 2'd1;
   localparam retire_state_t RS_HALTED = 2'd2;

   typedef struct packed {
      logic                          complete;
      logic                          mispredict;
      logic                          halt;
      logic                          has_dest;
      logic [RC_ARCH_REG_BITS-1:0]   arch_dest;
      logic [RC_PHYS_REG_IDX_SZ-1:0] t;
      logic [RC_PHYS_REG_IDX_SZ-1:0] t_old;
   } ROB_EXIT_PACKET;

   // An entry that redirects or stops the machine closes the retire group.
   function automatic logic ends_group(input ROB_EXIT_PACKET p);
      return p.mispredict | p.halt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/retire_scan.sv
// Combinational in-order prefix scan: which head lanes retire this cycle, and how many.
`default_nettype none

module retire_scan #(
   parameter int N               = 3,
   parameter int NUM_SCALAR_BITS = $clog2(N+1)
) (
   input  logic                       enable,
   input  logic [N-1:0]               complete,
   input  logic [N-1:0]               stop,
   input  logic [NUM_SCALAR_BITS-1:0] outputs_valid,
   output logic [N-1:0]               retire_mask,
   output logic [NUM_SCALAR_BITS-1:0] count
);

   logic alive;

   always_comb begin
      retire_mask = '0;
      count       = '0;
      alive       = enable;
      for (int i = 0; i < N; i++) begin
         if (alive && (NUM_SCALAR_BITS'(i) < outputs_valid) && complete[i]) begin
            retire_mask[i] = 1'b1;
            count          = count + NUM_SCALAR_BITS'(1);
            // A retiring mispredict/halt still retires, but nothing younger follows it.
            alive          = !stop[i];
         end else begin
            alive = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/retire_ctrl.sv
// In-order retirement controller: retire count, free-list/arch-map commit, flush and halt sequencing.
`default_nettype none

module retire_ctrl
   import retire_ctrl_pkg::*;
#(
   parameter int N               = RC_N,
   parameter int NUM_SCALAR_BITS = $clog2(N+1),
   parameter int PHYS_REG_BITS   = RC_PHYS_REG_IDX_SZ,
   parameter int ARCH_REG_BITS   = RC_ARCH_REG_BITS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  ROB_EXIT_PACKET             rob_outputs [N],
   input  logic [NUM_SCALAR_BITS-1:0] outputs_valid,
   input  logic                       ext_stall,
   output logic [NUM_SCALAR_BITS-1:0] num_retiring,
   output logic [N-1:0]               free_valid,
   output logic [PHYS_REG_BITS-1:0]   free_tag [N],
   output logic [N-1:0]               amt_wr_en,
   output logic [ARCH_REG_BITS-1:0]   amt_wr_idx [N],
   output logic [PHYS_REG_BITS-1:0]   amt_wr_tag [N],
   output logic                       flush,
   output logic                       halted,
   output logic [31:0]                retired_count
);

   retire_state_t state;
   retire_state_t state_next;

   logic [N-1:0] complete_vec;
   logic [N-1:0] stop_vec;
   logic [N-1:0] halt_vec;
   logic [N-1:0] misp_vec;
   logic [N-1:0] has_dest_vec;
   logic [N-1:0] retire_mask;
   logic         scan_enable;

   always_comb begin
      complete_vec = '0;
      stop_vec     = '0;
      halt_vec     = '0;
      misp_vec     = '0;
      has_dest_vec = '0;
      for (int i = 0; i < N; i++) begin
         complete_vec[i] = rob_outputs[i].complete;
         stop_vec[i]     = ends_group(rob_outputs[i]);
         halt_vec[i]     = rob_outputs[i].halt;
         misp_vec[i]     = rob_outputs[i].mispredict;
         has_dest_vec[i] = rob_outputs[i].has_dest;
      end
   end

   // Reset gating here keeps every combinational commit output quiet during reset.
   assign scan_enable = (state == RS_RUN) && !ext_stall && !reset;

   retire_scan #(
      .N               (N),
      .NUM_SCALAR_BITS (NUM_SCALAR_BITS)
   ) u_scan (
      .enable        (scan_enable),
      .complete      (complete_vec),
      .stop          (stop_vec),
      .outputs_valid (outputs_valid),
      .retire_mask   (retire_mask),
      .count         (num_retiring)
   );

   assign free_valid = retire_mask & has_dest_vec;
   assign amt_wr_en  = retire_mask & has_dest_vec;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         free_tag[i]   = PHYS_REG_BITS'(rob_outputs[i].t_old);
         amt_wr_idx[i] = ARCH_REG_BITS'(rob_outputs[i].arch_dest);
         amt_wr_tag[i] = PHYS_REG_BITS'(rob_outputs[i].t);
      end
   end

   // The scan stops at the first mispredict/halt, so at most one such lane can be in the mask.
   always_comb begin
      state_next = state;
      case (state)
         RS_RUN: begin
            if (|(retire_mask & halt_vec))
               state_next = RS_HALTED;
            else if (|(retire_mask & misp_vec))
               state_next = RS_FLUSH;
         end
         RS_FLUSH:  state_next = RS_RUN;
         RS_HALTED: state_next = RS_HALTED;
         default:   state_next = RS_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= RS_RUN;
         flush         <= 1'b0;
         halted        <= 1'b0;
         retired_count <= '0;
      end else begin
         state         <= state_next;
         flush         <= (state_next == RS_FLUSH);
         halted        <= (state_next == RS_HALTED);
         retired_count <= retired_count + 32'(num_retiring);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_retire_ctrl.sv
// Directed self-checking bench for retire_ctrl with N=3.
`default_nettype none

module tb_retire_ctrl;
   import retire_ctrl_pkg::*;

   localparam int N  = 3;
   localparam int SB = 2;
   localparam int PB = RC_PHYS_REG_IDX_SZ;
   localparam int AB = RC_ARCH_REG_BITS;

   logic           clock;
   logic           reset;
   ROB_EXIT_PACKET rob [N];
   logic [SB-1:0]  outputs_valid;
   logic           ext_stall;
   logic [SB-1:0]  num_retiring;
   logic [N-1:0]   free_valid;
   logic [PB-1:0]  free_tag [N];
   logic [N-1:0]   amt_wr_en;
   logic [AB-1:0]  amt_wr_idx [N];
   logic [PB-1:0]  amt_wr_tag [N];
   logic           flush;
   logic           halted;
   logic [31:0]    retired_count;

   int n_cmp = 0;
   int n_err = 0;

   retire_ctrl #(.N(N)) dut (
      .clock         (clock),
      .reset         (reset),
      .rob_outputs   (rob),
      .outputs_valid (outputs_valid),
      .ext_stall     (ext_stall),
      .num_retiring  (num_retiring),
      .free_valid    (free_valid),
      .free_tag      (free_tag),
      .amt_wr_en     (amt_wr_en),
      .amt_wr_idx    (amt_wr_idx),
      .amt_wr_tag    (amt_wr_tag),
      .flush         (flush),
      .halted        (halted),
      .retired_count (retired_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Bit i of each vector drives entry i; tags are fixed per lane.
   task automatic drive(input logic [2:0] cpl, input logic [2:0] misp, input logic [2:0] hlt,
                        input logic [2:0] hd, input logic [SB-1:0] vld, input logic stall);
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         rob[i].complete   = cpl[i];
         rob[i].mispredict = misp[i];
         rob[i].halt       = hlt[i];
         rob[i].has_dest   = hd[i];
      end
      rob[0].t_old = 6'd7;  rob[1].t_old = 6'd9;  rob[2].t_old = 6'd12;
      rob[0].t     = 6'd20; rob[1].t     = 6'd21; rob[2].t     = 6'd22;
      rob[0].arch_dest = 5'd1; rob[1].arch_dest = 5'd2; rob[2].arch_dest = 5'd3;
      outputs_valid = vld;
      ext_stall     = stall;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
      check("rst_num_retiring", 32'(num_retiring), 0);
      check("rst_free_valid", 32'(free_valid), 0);
      tick();
      check("rst_flush", 32'(flush), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_count", retired_count, 0);

      reset = 1'b0;
      drive(3'b011, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
      check("partial_num", 32'(num_retiring), 2);
      check("partial_free_valid", 32'(free_valid), 32'b011);
      tick();
      check("partial_count", retired_count, 2);

      drive(3'b110, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
      check("head_incomplete_num", 32'(num_retiring), 0);
      check("head_incomplete_free", 32'(free_valid), 0);
      check("head_incomplete_amt", 32'(amt_wr_en), 0);
      tick();
      check("head_incomplete_count", retired_count, 2);

      drive(3'b111, 3'b000, 3'b000, 3'b101, 2'd3, 1'b1);
      check("stall_num", 32'(num_retiring), 0);
      drive(3'b111, 3'b000, 3'b000, 3'b101, 2'd3, 1'b0);
      check("unstall_num", 32'(num_retiring), 3);
      check("dest_free_valid", 32'(free_valid), 32'b101);
      check("free_tag0", 32'(free_tag[0]), 7);
      check("free_tag2", 32'(free_tag[2]), 12);
      check("dest_amt_en", 32'(amt_wr_en), 32'b101);
      check("amt_idx2", 32'(amt_wr_idx[2]), 3);
      check("amt_tag0", 32'(amt_wr_tag[0]), 20);
      tick();
      check("unstall_count", retired_count, 5);

      drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd1, 1'b0);
      check("valid1_num", 32'(num_retiring), 1);
      tick();
      check("valid1_count", retired_count, 6);

      drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0);
      check("valid0_num", 32'(num_retiring), 0);

      drive(3'b111, 3'b001, 3'b000, 3'b111, 2'd3, 1'b1);
      check("stall_misp_num", 32'(num_retiring), 0);
      tick();
      check("stall_misp_flush", 32'(flush), 0);

      drive(3'b111, 3'b010, 3'b000, 3'b111, 2'd3, 1'b0);
      check("misp_num", 32'(num_retiring), 2);
      check("misp_free_valid", 32'(free_valid), 32'b011);
      tick();
      check("misp_flush", 32'(flush), 1);
      check("misp_count", retired_count, 8);
      drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
      check("flush_num", 32'(num_retiring), 0);
      check("flush_amt", 32'(amt_wr_en), 0);
      tick();
      check("post_flush_flush", 32'(flush), 0);
      check("post_flush_count", retired_count, 8);
      drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
      check("resume_num", 32'(num_retiring), 3);
      tick();
      check("resume_count", retired_count, 11);

      drive(3'b111, 3'b000, 3'b001, 3'b111, 2'd3, 1'b0);
      check("halt_num", 32'(num_retiring), 1);
      tick();
      check("halt_halted", 32'(halted), 1);
      check("halt_count", retired_count, 12);
      for (int k = 0; k < 10; k++) begin
         drive(3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 1'b0);
         check("halted_num", 32'(num_retiring), 0);
         tick();
         check("halted_hold", 32'(halted), 1);
      end
      check("halted_count_frozen", retired_count, 12);

      reset = 1'b1;
      tick();
      check("rst2_halted", 32'(halted), 0);
      check("rst2_count", retired_count, 0);
      check("rst2_flush", 32'(flush), 0);
      reset = 1'b0;

      drive(3'b111, 3'b010, 3'b010, 3'b111, 2'd3, 1'b0);
      check("halt_misp_num", 32'(num_retiring), 2);
      tick();
      check("halt_misp_halted", 32'(halted), 1);
      check("halt_misp_flush", 32'(flush), 0);
      check("halt_misp_count", retired_count, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
